// File: rtl/ifetch_pcgen_pkg.sv
// rtl/ifetch_pcgen_pkg.sv - shared fetch PC types, sizing constants and alignment helper
package ifetch_pcgen_pkg;

  localparam int LADDR_BITS     = 39;
  localparam int COREID_BITS    = 8;
  localparam int FETCH_BYTES    = 16;
  localparam int IFETCH_CREDITS = 8;
  localparam int CREDIT_W       = $clog2(IFETCH_CREDITS + 1);

  typedef struct packed {
    logic [COREID_BITS-1:0] coreid;
    logic [LADDR_BITS-1:0]  laddr;
  } I_coretoictlb_pc_type;

  // fb must be a power of two; clears the byte-within-block bits
  function automatic logic [LADDR_BITS-1:0] align_pc(input logic [LADDR_BITS-1:0] a,
                                                     input int fb);
    return a & ~LADDR_BITS'(fb - 1);
  endfunction

endpackage

// File: rtl/ifetch_pcgen_if.sv
// rtl/ifetch_pcgen_if.sv - fetch PC request channel, redirect and credit signals
interface ifetch_pcgen_if;
  import ifetch_pcgen_pkg::*;

  logic                  redirect_valid;
  logic [LADDR_BITS-1:0] redirect_pc;
  logic                  credit_return;
  logic                  coretoictlb_pc_valid;
  logic                  coretoictlb_pc_retry;
  I_coretoictlb_pc_type  coretoictlb_pc;
  logic [CREDIT_W-1:0]   credits_avail;

  modport master (
    input  redirect_valid, redirect_pc, credit_return, coretoictlb_pc_retry,
    output coretoictlb_pc_valid, coretoictlb_pc, credits_avail
  );

  modport slave (
    output redirect_valid, redirect_pc, credit_return, coretoictlb_pc_retry,
    input  coretoictlb_pc_valid, coretoictlb_pc, credits_avail
  );

endinterface

// File: rtl/ifetch_pcgen_credit_ctr.sv
// rtl/ifetch_pcgen_credit_ctr.sv - saturating up/down fetch-buffer credit counter
module ifetch_credit_ctr #(
  parameter int Max = 8,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_count_next,
  output logic         o_zero,
  output logic         o_full
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_next;

  assign o_zero = (r_count == '0);
  assign o_full = (r_count == W'(Max));

  // simultaneous inc and dec cancel; each direction clamps at its end
  always_comb begin
    w_next = r_count;
    if (i_inc && !i_dec && !o_full)
      w_next = r_count + W'(1);
    else if (i_dec && !i_inc && !o_zero)
      w_next = r_count - W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_count <= W'(Max);
    else
      r_count <= w_next;
  end

  assign o_count      = r_count;
  assign o_count_next = w_next;

endmodule

// File: rtl/ifetch_pcgen.sv
// rtl/ifetch_pcgen.sv - fetch PC generator feeding the ICTLB, with redirect and credit throttling
module ifetch_pcgen
  import ifetch_pcgen_pkg::*;
#(
  parameter int                      FetchBytes  = FETCH_BYTES,
  parameter int                      Credits     = IFETCH_CREDITS,
  parameter logic [LADDR_BITS-1:0]   ResetVector = '0,
  parameter logic [COREID_BITS-1:0]  CoreId      = '0
) (
  input  logic            clk,
  input  logic            reset,
  ifetch_pcgen_if.master  bus
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  localparam logic [LADDR_BITS-1:0] RESET_PC = align_pc(ResetVector, FetchBytes);

  logic [1:0]            r_state;
  logic [LADDR_BITS-1:0] r_pc;
  logic                  r_valid;

  logic [1:0]            w_state_next;
  logic [LADDR_BITS-1:0] w_pc_next;
  logic                  w_accept;
  logic [CREDIT_W-1:0]   w_count;
  logic [CREDIT_W-1:0]   w_count_next;
  logic                  w_zero;
  logic                  w_full;

  // a redirect squashes the current beat even if the ICTLB would have taken it
  assign w_accept = r_valid && !bus.coretoictlb_pc_retry && !bus.redirect_valid && !w_zero;

  ifetch_credit_ctr #(
    .Max (Credits),
    .W   (CREDIT_W)
  ) u_credit_ctr (
    .clk          (clk),
    .reset        (reset),
    .i_inc        (bus.credit_return),
    .i_dec        (w_accept),
    .o_count      (w_count),
    .o_count_next (w_count_next),
    .o_zero       (w_zero),
    .o_full       (w_full)
  );

  always_comb begin
    w_pc_next = r_pc;
    if (bus.redirect_valid)
      w_pc_next = align_pc(bus.redirect_pc, FetchBytes);
    else if (w_accept)
      w_pc_next = r_pc + LADDR_BITS'(FetchBytes);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_BOOT: w_state_next = ST_RUN;
      default: w_state_next = (w_count_next == '0) ? ST_STALL : ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_valid <= (w_state_next == ST_RUN);
    end
  end

  assign bus.coretoictlb_pc_valid = r_valid;
  assign bus.coretoictlb_pc       = {CoreId, r_pc};
  assign bus.credits_avail        = w_count;

  // a return with every entry already free indicates lost credit accounting downstream
  a_credit_overflow: assert property (@(posedge clk) disable iff (reset)
    !(bus.credit_return && w_full && !w_accept));

endmodule
